truth_table_logic_engine: RTL and testbench
===========================================

// Module: truth_table_logic_engine
// PURPOSE
//  Parametrised, clocked successor to our fixed 4-input NOR/NOT logic designs.
//  Evaluates N_CH independent N_IN-input Boolean functions. Each function is a
//  runtime-loadable 2^N_IN-bit truth table with double-buffered configuration.
//  Evaluation is 1-cycle latency behind a valid/ready handshake.
//  A built-in sweep FSM walks every input combination and reports a per-channel
//  ones-count, so a loaded design can be checked in silicon or simulation.
// PARAMETERS
//  N_IN        4          inputs per channel; truth table is 2^N_IN bits
//  N_CH        2          number of independent channels
//  DEFAULT_TT  16'h1714   reset truth table for every channel, width 2^N_IN
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  cfg_we       in   1              write cfg_tt into the shadow table of cfg_ch
//  cfg_ch       in   clog2(N_CH)    target channel (min width 1)
//  cfg_tt       in   2^N_IN         truth table; bit i = output for input index i
//  cfg_commit   in   1              copy all shadow tables to active tables
//  in_valid     in   1              in_vec valid
//  in_ready     out  1              engine accepts in_vec this cycle
//  in_vec       in   N_CH*N_IN      channel c inputs = in_vec[c*N_IN +: N_IN]
//  out_valid    out  1              out_vec valid
//  out_ready    in   1              consumer accepts out_vec
//  out_vec      out  N_CH           out_vec[c] = active_tt[c][index_c]
//  sweep_start  in   1              start self-sweep (honoured in IDLE only)
//  sweep_busy   out  1              sweep in progress
//  sweep_done   out  1              1-cycle pulse at sweep end
//  sweep_ones   out  N_CH*(N_IN+1)  per-channel count of 1 outputs over the sweep
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - active and shadow tables = DEFAULT_TT
//   - out_valid=0, out_vec=0, sweep_busy=0, sweep_done=0, sweep_ones=0
//   - commit_pend=0, FSM=IDLE
//   - Reset mid-sweep or mid-transfer aborts it; no partial result is kept.
//  Config:
//   - cfg_we writes shadow[cfg_ch]; a write with cfg_ch >= N_CH is ignored.
//   - cfg_commit copies all shadows to active at the clock edge.
//   - cfg_we and cfg_commit in the same cycle: the commit includes the new write.
//   - A commit during RUN sets commit_pend. The copy then happens on the DONE
//     cycle, so a sweep always uses one consistent table set.
//   - A held out_vec is never altered by a commit.
//  Eval handshake:
//   - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
//   - Transfer when in_valid && in_ready. Next edge: out_valid=1, out_vec
//     computed from the active tables as they were at the transfer edge.
//   - out_valid && !out_ready: out_vec is held stable.
//   - Full throughput: 1 transfer per cycle when out_ready=1.
//   - out_valid falls when out_ready=1 and no new transfer occurs.
//  Sweep FSM (IDLE -> RUN -> DONE -> IDLE):
//   - IDLE->RUN: sweep_start && !out_valid. sweep_start while out_valid=1 is
//     held off until output drains; sweep_start is not latched.
//   - On entry: idx=0, ones counters cleared.
//   - RUN: sweep_busy=1 and in_ready=0.
//   - Each RUN cycle: ones[c] += active[c][idx]; idx += 1.
//   - RUN lasts exactly 2^N_IN cycles, ending after idx = 2^N_IN-1 with no
//     idx overflow.
//   - DONE: single cycle. sweep_done=1, sweep_busy=0, sweep_ones updated and
//     held until the next RUN entry.
//   - sweep_start during RUN or DONE is ignored.
//   - Counter width N_IN+1 holds the maximum value 2^N_IN without wrap.
// TESTING
//  1 Reset, ch0 in=4'd2 -> next cycle out_valid=1, out_vec[0]=1; in=4'd3 -> 0;
//    in=4'd4 -> 1.
//  2 out_ready=0 for 3 cycles after a transfer -> in_ready=0, out_vec stable;
//    out_ready=1 -> next in_vec accepted that cycle.
//  3 cfg_we ch1 16'hFFFF, no commit -> ch1 still follows 16'h1714;
//    commit -> ch1=1 for all 16 inputs; ch0 unchanged.
//  4 Default tables, sweep_start -> sweep_busy high exactly 16 cycles,
//    sweep_done pulse, sweep_ones = {5'd6, 5'd6}.
//  5 Commit of ch0=16'h0000 mid-sweep -> sweep_ones[ch0]=6;
//    after DONE, ch0 evaluates 0.
//  6 rst_n low mid-sweep, async -> busy/done/ones=0, tables=DEFAULT_TT,
//    in_ready=1 after release.

Source files
------------

// File: rtl/truth_table_logic_engine.sv
// N_CH independent N_IN-input Boolean functions held as runtime-loadable truth tables.
// Tables are double-buffered, evaluation sits behind a valid/ready handshake, and a sweep FSM counts ones per channel.
module truth_table_logic_engine #(
    parameter int                     N_IN       = 4,
    parameter int                     N_CH       = 2,
    parameter logic [(1<<N_IN)-1:0]   DEFAULT_TT = 16'h1714
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [(1<<N_IN)-1:0]                  cfg_tt,
    input  logic                                  cfg_commit,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_CH*N_IN-1:0]                  in_vec,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_CH-1:0]                       out_vec,
    input  logic                                  sweep_start,
    output logic                                  sweep_busy,
    output logic                                  sweep_done,
    output logic [N_CH*(N_IN+1)-1:0]              sweep_ones
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = N_IN + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic              commit_pend;

    logic [TT_W-1:0]   shadow     [N_CH];
    logic [TT_W-1:0]   shadow_nxt [N_CH];
    logic [TT_W-1:0]   active     [N_CH];

    logic              cfg_hit;
    logic              do_commit;
    logic              xfer_p0;
    logic [N_CH-1:0]   lookup_p0;

    function automatic logic tt_lookup(input logic [TT_W-1:0] tt, input logic [N_IN-1:0] sel);
        return tt[sel];
    endfunction

    // Shadow write is merged before the commit so a same-cycle write+commit lands in the active set.
    always_comb begin
        cfg_hit = cfg_we && (int'(cfg_ch) < N_CH);
        for (int c = 0; c < N_CH; c++) begin
            shadow_nxt[c] = shadow[c];
            if (cfg_hit && (int'(cfg_ch) == c)) begin
                shadow_nxt[c] = cfg_tt;
            end
        end
    end

    // Commits arriving during a sweep are deferred to DONE so one sweep sees one table set.
    always_comb begin
        do_commit = 1'b0;
        case (state)
            IDLE:    do_commit = cfg_commit;
            DONE:    do_commit = cfg_commit || commit_pend;
            default: do_commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                shadow[c] <= DEFAULT_TT;
                active[c] <= DEFAULT_TT;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                shadow[c] <= shadow_nxt[c];
                if (do_commit) begin
                    active[c] <= shadow_nxt[c];
                end
            end
        end
    end

    // Stage p0: handshake and table lookup against the tables as they stand before this edge.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign xfer_p0  = in_valid && in_ready;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            lookup_p0[c] = tt_lookup(active[c], in_vec[c*N_IN +: N_IN]);
        end
    end

    // Stage p1: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else if (xfer_p0) begin
            out_valid <= 1'b1;
            out_vec   <= lookup_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sweep FSM; sweep_ones doubles as the running accumulator and is cleared on RUN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            commit_pend <= 1'b0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_ones  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sweep_done <= 1'b0;
                    if (sweep_start && !out_valid) begin
                        state      <= RUN;
                        idx        <= '0;
                        sweep_busy <= 1'b1;
                        sweep_ones <= '0;
                    end
                end
                RUN: begin
                    for (int c = 0; c < N_CH; c++) begin
                        sweep_ones[c*CNT_W +: CNT_W] <= sweep_ones[c*CNT_W +: CNT_W]
                                                        + CNT_W'(tt_lookup(active[c], idx));
                    end
                    if (cfg_commit) begin
                        commit_pend <= 1'b1;
                    end
                    if (idx == '1) begin
                        state      <= DONE;
                        sweep_busy <= 1'b0;
                        sweep_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    sweep_done  <= 1'b0;
                    commit_pend <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_logic_engine.sv
// Scoreboard bench for truth_table_logic_engine: expected out_vec values are queued at transfer
// and compared when the output is consumed; sweep and reset behaviour checked against constants.
module tb_truth_table_logic_engine;

    localparam int N_IN  = 4;
    localparam int N_CH  = 2;
    localparam int TT_W  = 16;
    localparam logic [15:0] DEF_TT = 16'h1714;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_tt;
    logic        cfg_commit;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_vec;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [9:0]  sweep_ones;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model_active [N_CH];
    logic [15:0] model_shadow [N_CH];
    logic [1:0]  exp_q [$];
    bit          in_sweep = 1'b0;

    always #5 clk = ~clk;

    truth_table_logic_engine #(
        .N_IN       (N_IN),
        .N_CH       (N_CH),
        .DEFAULT_TT (DEF_TT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_tt      (cfg_tt),
        .cfg_commit  (cfg_commit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_ones  (sweep_ones)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_eval(input logic [7:0] v);
        logic [1:0] r;
        for (int c = 0; c < N_CH; c++) begin
            r[c] = model_active[c][v[c*N_IN +: N_IN]];
        end
        return r;
    endfunction

    function automatic logic [9:0] model_ones();
        logic [9:0] r;
        for (int c = 0; c < N_CH; c++) begin
            r[c*5 +: 5] = 5'($countones(model_active[c]));
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            model_active[c] = DEF_TT;
            model_shadow[c] = DEF_TT;
        end
        exp_q.delete();
    endtask

    // One clock: settle, score consumption/transfer on pre-edge values, advance, sample 1 after the edge.
    task automatic tick();
        logic [1:0] e;
        #1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", 32'(out_vec), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_vec", 32'(out_vec), 32'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_eval(in_vec));
            if (cfg_we) model_shadow[cfg_ch] = cfg_tt;
            if (cfg_commit && !in_sweep) begin
                for (int c = 0; c < N_CH; c++) model_active[c] = model_shadow[c];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream16(input logic [3:0] ofs);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_vec = {4'(i), 4'(i + int'(ofs))};
            #1;
            check("full_tp_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);
    endtask

    task automatic run_sweep(input int commit_at, output int busy_cnt, output bit done_seen);
        busy_cnt  = 0;
        done_seen = 1'b0;
        in_sweep  = 1'b1;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sweep_done) begin
                done_seen = 1'b1;
                break;
            end
            if (sweep_busy) busy_cnt++;
            if (i == commit_at) begin
                cfg_we = 1'b1; cfg_ch = 1'b0; cfg_tt = 16'h0000; cfg_commit = 1'b1;
            end else begin
                cfg_we = 1'b0; cfg_commit = 1'b0;
            end
            tick();
        end
        cfg_we = 1'b0; cfg_commit = 1'b0;
        in_sweep = 1'b0;
    endtask

    int         busy_cnt;
    bit         done_seen;
    logic [1:0] held;
    logic [9:0] exp_ones;

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_tt = '0; cfg_commit = 1'b0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; sweep_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_vec",   32'(out_vec),   32'd0);
        check("rst_busy",      32'(sweep_busy), 32'd0);
        check("rst_done",      32'(sweep_done), 32'd0);
        check("rst_ones",      32'(sweep_ones), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready), 32'd1);

        // Basic evaluation, 1-cycle latency
        in_valid = 1'b1; in_vec = {4'd0, 4'd2};
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_in2",   32'(out_vec[0]), 32'd1);
        in_vec = {4'd7, 4'd3};
        tick();
        check("t1_in3",   32'(out_vec[0]), 32'd0);
        in_vec = {4'd15, 4'd4};
        tick();
        check("t1_in4",   32'(out_vec[0]), 32'd1);
        in_valid = 1'b0;
        tick();
        check("t1_valid_fall", 32'(out_valid), 32'd0);

        // Backpressure holds output and blocks input
        in_valid = 1'b1; in_vec = {4'd4, 4'd5};
        tick();
        held = out_vec;
        out_ready = 1'b0; in_vec = {4'd2, 4'd6};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_ready_low", 32'(in_ready), 32'd0);
            tick();
            check("t2_hold_vec",   32'(out_vec),   32'(held));
            check("t2_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t2_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("t2_new_vec", 32'(out_vec), 32'(model_eval({4'd2, 4'd6})));
        in_valid = 1'b0;
        tick();

        // Sweep with default tables
        run_sweep(-1, busy_cnt, done_seen);
        check("t4_done_seen", 32'(done_seen), 32'd1);
        check("t4_busy_cycles", 32'(busy_cnt), 32'd16);
        check("t4_busy_in_done", 32'(sweep_busy), 32'd0);
        check("t4_ones", 32'(sweep_ones), 32'({5'd6, 5'd6}));
        tick();
        check("t4_done_pulse", 32'(sweep_done), 32'd0);
        check("t4_ones_held", 32'(sweep_ones), 32'({5'd6, 5'd6}));

        // Shadow write without commit, then commit
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_tt = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        stream16(4'd3);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        stream16(4'd9);

        // Commit mid-sweep is deferred to DONE
        run_sweep(5, busy_cnt, done_seen);
        exp_ones = model_ones();
        check("t5_done_seen", 32'(done_seen), 32'd1);
        check("t5_busy_cycles", 32'(busy_cnt), 32'd16);
        check("t5_ones", 32'(sweep_ones), 32'(exp_ones));
        check("t5_ones_ch0", 32'(sweep_ones[4:0]), 32'd6);
        tick();
        for (int c = 0; c < N_CH; c++) model_active[c] = model_shadow[c];
        in_valid = 1'b1; in_vec = {4'd0, 4'd2};
        tick();
        check("t5_ch0_zero", 32'(out_vec[0]), 32'd0);
        check("t5_ch1_one",  32'(out_vec[1]), 32'd1);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-sweep
        in_sweep = 1'b1;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (6) tick();
        check("t6_busy_before", 32'(sweep_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_async", 32'(sweep_busy), 32'd0);
        check("t6_done_async", 32'(sweep_done), 32'd0);
        check("t6_ones_async", 32'(sweep_ones), 32'd0);
        check("t6_valid_async", 32'(out_valid), 32'd0);
        in_sweep = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t6_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b1; in_vec = {4'd2, 4'd2};
        tick();
        check("t6_default_tt", 32'(out_vec), 32'd3);
        in_vec = {4'd3, 4'd4};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
